// File: rtl/pc_flag_unit.sv
// pc_flag_unit: retire stage holding flags and PC, resolving branches and HLT
module pc_flag_unit #(
  parameter int PC_W = 12,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [15:0]     instr,
  input  logic [15:0]     alu_x,
  input  logic [3:0]      alu_code,
  output logic [PC_W-1:0] pc,
  output logic            pc_valid,
  output logic [3:0]      flags,
  output logic            taken,
  output logic            halted,
  output logic [15:0]     retired
);
  typedef enum logic [1:0] {IDLE, RUN, FLUSH, HALT} state_t;
  state_t state, state_nx;
  logic [3:0] op;
  logic accept, is_alu, is_hlt, is_b, is_bc, cond_ok, take, s, z, v;
  assign op = instr[7:4];
  assign {s, z, v} = {flags[3], flags[2], flags[0]};
  always_comb begin
    is_alu = instr[15:14] == 2'b11 && (op inside {4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h8});
    is_hlt = instr[15:14] == 2'b11 && op == 4'hF;
    is_b = instr[15:11] == 5'b10100;
    is_bc = instr[15:11] == 5'b10111;
    cond_ok = instr[10] ? 1'b0 :
              instr[9:8] == 2'd0 ? z :
              instr[9:8] == 2'd1 ? s ^ v :
              instr[9:8] == 2'd2 ? z | (s ^ v) : !z;
    take = is_b | (is_bc & cond_ok);
    in_ready = state == RUN;
    pc_valid = state == RUN;
    halted = state == HALT;
    accept = in_ready && in_valid;
    state_nx = state;
    case (state)
      IDLE:  state_nx = start ? RUN : IDLE;
      RUN:   state_nx = !accept ? RUN : is_hlt ? HALT : take ? FLUSH : RUN;
      FLUSH: state_nx = RUN;
      HALT:  state_nx = start ? RUN : HALT;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
      flags <= 4'b0000;
      taken <= 1'b0;
      retired <= 16'd0;
    end else begin
      taken <= accept && take;
      if (accept) begin
        retired <= retired + 16'd1;
        if (is_alu) flags <= alu_code;
        if (take) pc <= alu_x[PC_W-1:0];
        else if (!is_hlt) pc <= pc + 1'b1;
      end else if (state == HALT && start) begin
        pc <= pc + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_pc_flag_unit.sv
// tb_pc_flag_unit: vector table plus scoreboard checks for pc_flag_unit
module tb_pc_flag_unit;
  logic clk = 0, rst_n, start, in_valid, in_ready, pc_valid, taken, halted;
  logic [15:0] instr, alu_x, retired;
  logic [3:0] alu_code, flags;
  logic [11:0] pc;
  int n_tests = 0, n_fail = 0;
  logic [15:0] ret_m;
  logic [11:0] pc_m;

  typedef struct {
    logic [15:0] instr, x;
    logic [3:0] code;
    logic [11:0] pc;
    logic [3:0] flags;
    logic taken, halted;
  } vec_t;
  typedef struct {
    logic [11:0] pc;
    logic [3:0] flags;
    logic taken, halted;
    logic [15:0] ret;
  } exp_t;
  vec_t vt[19];
  exp_t sb[$];
  exp_t e;

  pc_flag_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .alu_x(alu_x), .alu_code(alu_code), .pc(pc), .pc_valid(pc_valid),
    .flags(flags), .taken(taken), .halted(halted), .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1;
    @(negedge clk);
    start = 0;
  endtask

  initial begin
    vt[0]  = '{16'hC000, 16'h0000, 4'b1000, 12'h001, 4'b1000, 1'b0, 1'b0};
    vt[1]  = '{16'hC000, 16'h0000, 4'b0100, 12'h002, 4'b0100, 1'b0, 1'b0};
    vt[2]  = '{16'hC000, 16'h0000, 4'b0010, 12'h003, 4'b0010, 1'b0, 1'b0};
    vt[3]  = '{16'hC050, 16'h0000, 4'b0100, 12'h004, 4'b0100, 1'b0, 1'b0};
    vt[4]  = '{16'hB800, 16'h0040, 4'b1111, 12'h040, 4'b0100, 1'b1, 1'b0};
    vt[5]  = '{16'hBB00, 16'h0080, 4'b1111, 12'h041, 4'b0100, 1'b0, 1'b0};
    vt[6]  = '{16'hC060, 16'h0000, 4'b1111, 12'h042, 4'b0100, 1'b0, 1'b0};
    vt[7]  = '{16'hC080, 16'h0000, 4'b1000, 12'h043, 4'b1000, 1'b0, 1'b0};
    vt[8]  = '{16'hB900, 16'h0100, 4'b0000, 12'h100, 4'b1000, 1'b1, 1'b0};
    vt[9]  = '{16'hC010, 16'h0000, 4'b1001, 12'h101, 4'b1001, 1'b0, 1'b0};
    vt[10] = '{16'hB900, 16'h0200, 4'b0000, 12'h102, 4'b1001, 1'b0, 1'b0};
    vt[11] = '{16'hBA00, 16'h0200, 4'b0000, 12'h103, 4'b1001, 1'b0, 1'b0};
    vt[12] = '{16'hC020, 16'h0000, 4'b0100, 12'h104, 4'b0100, 1'b0, 1'b0};
    vt[13] = '{16'hBA00, 16'h0300, 4'b0000, 12'h300, 4'b0100, 1'b1, 1'b0};
    vt[14] = '{16'hBD00, 16'h0500, 4'b0000, 12'h301, 4'b0100, 1'b0, 1'b0};
    vt[15] = '{16'hA000, 16'hFFFF, 4'b0000, 12'hFFF, 4'b0100, 1'b1, 1'b0};
    vt[16] = '{16'h0000, 16'h0000, 4'b1111, 12'h000, 4'b0100, 1'b0, 1'b0};
    vt[17] = '{16'hA000, 16'h0010, 4'b0000, 12'h010, 4'b0100, 1'b1, 1'b0};
    vt[18] = '{16'hC0F0, 16'h0000, 4'b1111, 12'h010, 4'b0100, 1'b0, 1'b1};

    rst_n = 0; start = 0; in_valid = 0; instr = 0; alu_x = 0; alu_code = 0;
    repeat (2) @(negedge clk);
    chk("rst_pc", pc, 0); chk("rst_flags", flags, 0); chk("rst_retired", retired, 0);
    chk("rst_in_ready", in_ready, 0); chk("rst_pc_valid", pc_valid, 0);
    chk("rst_halted", halted, 0); chk("rst_taken", taken, 0);
    rst_n = 1;
    repeat (3) @(negedge clk);
    chk("idle_in_ready", in_ready, 0); chk("idle_pc_valid", pc_valid, 0);
    pulse_start();
    chk("run_in_ready", in_ready, 1); chk("run_pc_valid", pc_valid, 1);
    instr = 16'hC000; alu_code = 4'b1111; in_valid = 1;
    @(negedge clk);
    chk("pre_rst_pc", pc, 1); chk("pre_rst_flags", flags, 4'b1111); chk("pre_rst_ret", retired, 1);
    #2 rst_n = 0;
    #1;
    chk("mid_rst_pc", pc, 0); chk("mid_rst_flags", flags, 0); chk("mid_rst_ret", retired, 0);
    chk("mid_rst_in_ready", in_ready, 0); chk("mid_rst_pc_valid", pc_valid, 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("idle_ignores_valid", retired, 0); chk("idle_pc", pc, 0);
    in_valid = 0;
    pulse_start();

    ret_m = 0;
    for (int i = 0; i < 19; i++) begin
      instr = vt[i].instr; alu_x = vt[i].x; alu_code = vt[i].code; in_valid = 1;
      ret_m++;
      sb.push_back('{vt[i].pc, vt[i].flags, vt[i].taken, vt[i].halted, ret_m});
      @(negedge clk);
      in_valid = 0;
      e = sb.pop_front();
      chk($sformatf("v%0d_pc", i), pc, e.pc);
      chk($sformatf("v%0d_flags", i), flags, e.flags);
      chk($sformatf("v%0d_taken", i), taken, e.taken);
      chk($sformatf("v%0d_halted", i), halted, e.halted);
      chk($sformatf("v%0d_retired", i), retired, e.ret);
      if (e.taken) begin
        chk($sformatf("v%0d_flush_ready", i), in_ready, 0);
        @(negedge clk);
        chk($sformatf("v%0d_taken_drop", i), taken, 0);
        chk($sformatf("v%0d_run_after", i), in_ready, 1);
      end
    end

    instr = 16'hC000; alu_code = 4'b0001; in_valid = 1;
    repeat (3) @(negedge clk);
    chk("halt_pc_hold", pc, 12'h010); chk("halt_ret_hold", retired, ret_m);
    chk("halt_flags_hold", flags, 4'b0100); chk("halt_in_ready", in_ready, 0);
    in_valid = 0;
    pulse_start();
    chk("resume_pc", pc, 12'h011); chk("resume_ready", in_ready, 1); chk("resume_halted", halted, 0);
    pulse_start();
    @(negedge clk);
    chk("run_start_pc", pc, 12'h011); chk("run_start_ret", retired, ret_m);

    pc_m = 12'h011 + 12'(16'd0 - ret_m);
    instr = 16'h0000; in_valid = 1;
    repeat (int'(17'h10000 - {1'b0, ret_m}) - 1) @(negedge clk);
    chk("ret_ffff", retired, 16'hFFFF);
    @(negedge clk);
    in_valid = 0;
    chk("ret_wrap", retired, 0); chk("ret_wrap_pc", pc, pc_m);
    @(negedge clk);
    chk("ret_wrap_hold", retired, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
